dport_arbiter: RTL and testbench

- Shares the core's single debug-port request/response channel (the dport into the core's debug-port state machine) between two debug masters: master 0 is the DMI/abstract-command path, master 1 is the non-intrusive profiler/trace sampler.
- Round-robin grant with one outstanding transaction.
- Responses are registered and routed back to the granted master.
- A response timeout returns an error to the master and drains the late core response.

---
 rtl/dport_arbiter.sv | 169 ++++++++++++++++
 tb/tb_dport_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dport_arbiter.sv
// Round-robin arbiter sharing the core debug port between DMI (master 0) and the profiler (master 1).
// One outstanding transaction; registered responses; timeout returns an error and drains the late reply.
module dport_arbiter #(
  parameter int abits    = 64,
  parameter int tmo_bits = 10
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [1:0]         i_req_valid,
  output logic [1:0]         o_req_ready,
  input  logic [1:0]         i_req_write,
  input  logic [2*abits-1:0] i_req_addr,
  input  logic [2*abits-1:0] i_req_wdata,
  input  logic [3:0]         i_req_size,
  output logic [1:0]         o_resp_valid,
  input  logic [1:0]         i_resp_ready,
  output logic [abits-1:0]   o_resp_rdata,
  output logic               o_resp_error,
  output logic               o_dport_req_valid,
  input  logic               i_dport_req_ready,
  output logic               o_dport_write,
  output logic [abits-1:0]   o_dport_addr,
  output logic [abits-1:0]   o_dport_wdata,
  output logic [1:0]         o_dport_size,
  input  logic               i_dport_resp_valid,
  output logic               o_dport_resp_ready,
  input  logic [abits-1:0]   i_dport_rdata,
  input  logic               i_dport_resp_error,
  output logic               o_busy,
  output logic [7:0]         o_tmo_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_RESPONSE,
    ST_DELIVER,
    ST_DRAIN
  } state_t;

  localparam logic [tmo_bits-1:0] TMO_MAX = {tmo_bits{1'b1}};

  state_t              state_q, state_d;
  logic                rr_q, rr_d;          // master favoured on the next tie
  logic                g_q, g_d;
  logic                drain_q, drain_d;
  logic                wr_q, wr_d;
  logic [abits-1:0]    addr_q, addr_d;
  logic [abits-1:0]    wdata_q, wdata_d;
  logic [1:0]          size_q, size_d;
  logic [abits-1:0]    rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [tmo_bits-1:0] cnt_q, cnt_d;
  logic [7:0]          tmo_cnt_q, tmo_cnt_d;
  logic                win;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      rr_q      <= 1'b0;
      g_q       <= 1'b0;
      drain_q   <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      g_q       <= g_d;
      drain_q   <= drain_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    rr_d               = rr_q;
    g_d                = g_q;
    drain_d            = drain_q;
    wr_d               = wr_q;
    addr_d             = addr_q;
    wdata_d            = wdata_q;
    size_d             = size_q;
    rdata_d            = rdata_q;
    err_d              = err_q;
    cnt_d              = cnt_q;
    tmo_cnt_d          = tmo_cnt_q;
    win                = 1'b0;
    o_req_ready        = 2'b00;
    o_resp_valid       = 2'b00;
    o_dport_req_valid  = 1'b0;
    o_dport_resp_ready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|i_req_valid) begin
          win              = (&i_req_valid) ? rr_q : i_req_valid[1];
          o_req_ready[win] = 1'b1;
          g_d              = win;
          wr_d             = win ? i_req_write[1] : i_req_write[0];
          addr_d           = win ? i_req_addr[2*abits-1:abits]  : i_req_addr[abits-1:0];
          wdata_d          = win ? i_req_wdata[2*abits-1:abits] : i_req_wdata[abits-1:0];
          size_d           = win ? i_req_size[3:2] : i_req_size[1:0];
          state_d          = ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        o_dport_req_valid = 1'b1;
        if (i_dport_req_ready) begin
          cnt_d   = '0;
          state_d = ST_RESPONSE;
        end
      end
      ST_RESPONSE: begin
        o_dport_resp_ready = 1'b1;
        cnt_d              = cnt_q + 1'b1;
        // A response landing on the final count still wins over the timeout.
        if (i_dport_resp_valid) begin
          rdata_d = i_dport_rdata;
          err_d   = i_dport_resp_error;
          state_d = ST_DELIVER;
        end else if (cnt_q == TMO_MAX) begin
          rdata_d   = '0;
          err_d     = 1'b1;
          drain_d   = 1'b1;
          tmo_cnt_d = (tmo_cnt_q == 8'hFF) ? tmo_cnt_q : tmo_cnt_q + 8'd1;
          state_d   = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        o_resp_valid[g_q] = 1'b1;
        if (i_resp_ready[g_q]) begin
          rr_d    = ~g_q;
          state_d = drain_q ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        o_dport_resp_ready = 1'b1;
        if (i_dport_resp_valid) begin
          drain_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_dport_write = wr_q;
  assign o_dport_addr  = addr_q;
  assign o_dport_wdata = wdata_q;
  assign o_dport_size  = size_q;
  assign o_resp_rdata  = rdata_q;
  assign o_resp_error  = err_q;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_tmo_cnt     = tmo_cnt_q;

endmodule

// File: tb/tb_dport_arbiter.sv
// Directed bench for dport_arbiter with a short timeout (tmo_bits=4, limit 15).
module tb_dport_arbiter;
  localparam int AB = 64;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [1:0]    i_req_valid;
  logic [1:0]    o_req_ready;
  logic [1:0]    i_req_write;
  logic [2*AB-1:0] i_req_addr;
  logic [2*AB-1:0] i_req_wdata;
  logic [3:0]    i_req_size;
  logic [1:0]    o_resp_valid;
  logic [1:0]    i_resp_ready;
  logic [AB-1:0] o_resp_rdata;
  logic          o_resp_error;
  logic          o_dport_req_valid;
  logic          i_dport_req_ready;
  logic          o_dport_write;
  logic [AB-1:0] o_dport_addr;
  logic [AB-1:0] o_dport_wdata;
  logic [1:0]    o_dport_size;
  logic          i_dport_resp_valid;
  logic          o_dport_resp_ready;
  logic [AB-1:0] i_dport_rdata;
  logic          i_dport_resp_error;
  logic          o_busy;
  logic [7:0]    o_tmo_cnt;

  int checks = 0;
  int failures = 0;

  dport_arbiter #(.abits(AB), .tmo_bits(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_write(i_req_write), .i_req_addr(i_req_addr),
    .i_req_wdata(i_req_wdata), .i_req_size(i_req_size),
    .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
    .o_resp_rdata(o_resp_rdata), .o_resp_error(o_resp_error),
    .o_dport_req_valid(o_dport_req_valid), .i_dport_req_ready(i_dport_req_ready),
    .o_dport_write(o_dport_write), .o_dport_addr(o_dport_addr),
    .o_dport_wdata(o_dport_wdata), .o_dport_size(o_dport_size),
    .i_dport_resp_valid(i_dport_resp_valid), .o_dport_resp_ready(o_dport_resp_ready),
    .i_dport_rdata(i_dport_rdata), .i_dport_resp_error(i_dport_resp_error),
    .o_busy(o_busy), .o_tmo_cnt(o_tmo_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_req_valid        = 2'b00;
    i_req_write        = 2'b00;
    i_req_addr         = '0;
    i_req_wdata        = '0;
    i_req_size         = 4'b0000;
    i_resp_ready       = 2'b00;
    i_dport_req_ready  = 1'b0;
    i_dport_resp_valid = 1'b0;
    i_dport_rdata      = '0;
    i_dport_resp_error = 1'b0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    tick();
  endtask

  // Complete one transaction for master m with an always-ready core and master.
  task automatic run_txn(input int m);
    i_req_valid        = (m == 1) ? 2'b10 : 2'b01;
    i_dport_req_ready  = 1'b1;
    i_dport_resp_valid = 1'b1;
    i_resp_ready       = 2'b11;
    tick();
    i_req_valid = 2'b00;
    tick();
    tick();
    tick();
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    i_rst = 1'b1;
    #1;
    checks++;
    if ({o_req_ready, o_resp_valid, o_dport_req_valid, o_dport_resp_ready, o_busy} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0", {o_req_ready, o_resp_valid, o_dport_req_valid, o_dport_resp_ready, o_busy});
    end
    checks++;
    if ({o_resp_rdata, o_resp_error, o_dport_addr, o_dport_wdata, o_dport_write, o_dport_size} !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h/%h exp=0", o_resp_rdata, o_dport_addr, o_dport_wdata);
    end
    checks++;
    if (o_tmo_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_tmo_cnt got=%0d exp=0", o_tmo_cnt);
    end
    tick();
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    reset_dut();
    i_req_valid       = 2'b01;
    i_req_addr        = {64'h0, 64'h1000};
    i_req_size        = 4'b0011;
    i_dport_req_ready = 1'b1;
    #1;
    checks++;
    if (o_req_ready !== 2'b01) begin
      failures++;
      $display("FAIL rd_req_ready got=%b exp=01", o_req_ready);
    end
    tick();
    i_req_valid = 2'b00;
    checks++;
    if ({o_dport_req_valid, o_dport_write, o_dport_addr} !== {1'b1, 1'b0, 64'h1000}) begin
      failures++;
      $display("FAIL rd_dport_req got=%b/%b/%h exp=1/0/1000", o_dport_req_valid, o_dport_write, o_dport_addr);
    end
    tick();
    tick();
    i_dport_resp_valid = 1'b1;
    i_dport_rdata      = 64'hDEADBEEF;
    tick();
    i_dport_resp_valid = 1'b0;
    checks++;
    if ({o_resp_valid, o_resp_rdata, o_resp_error} !== {2'b01, 64'hDEADBEEF, 1'b0}) begin
      failures++;
      $display("FAIL rd_resp got=%b/%h/%b exp=01/deadbeef/0", o_resp_valid, o_resp_rdata, o_resp_error);
    end
    i_resp_ready = 2'b01;
    tick();
    i_resp_ready = 2'b00;
    checks++;
    if ({o_busy, o_resp_valid} !== 3'b000) begin
      failures++;
      $display("FAIL rd_idle got busy=%b resp_valid=%b exp=0/00", o_busy, o_resp_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] got [4];
    int n = 0;
    reset_dut();
    i_req_valid        = 2'b11;
    i_dport_req_ready  = 1'b1;
    i_dport_resp_valid = 1'b1;
    i_resp_ready       = 2'b11;
    #1;
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      checks++;
      if (o_req_ready === 2'b11) begin
        failures++;
        $display("FAIL rr_both_ready got=%b exp=one-hot or 00", o_req_ready);
      end
      if (o_req_ready != 2'b00) begin
        got[n] = o_req_ready;
        n++;
      end
      tick();
    end
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL rr_grant_count got=%0d exp=4", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got[i] !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL rr_order idx=%0d got=%b exp=%b", i, got[i], (i % 2 == 1) ? 2'b10 : 2'b01);
      end
    end
    clear_inputs();
  endtask

  task automatic test_req_stall();
    reset_dut();
    i_req_valid = 2'b10;
    i_req_write = 2'b10;
    i_req_addr  = {64'h2000, 64'h0};
    i_req_wdata = {64'h55AA, 64'h0};
    i_req_size  = 4'b1000;
    #1;
    checks++;
    if (o_req_ready !== 2'b10) begin
      failures++;
      $display("FAIL wr_req_ready got=%b exp=10", o_req_ready);
    end
    tick();
    i_req_valid = 2'b00;
    i_req_addr  = '1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({o_dport_req_valid, o_dport_write, o_dport_addr, o_dport_wdata, o_dport_size} !==
          {1'b1, 1'b1, 64'h2000, 64'h55AA, 2'b10}) begin
        failures++;
        $display("FAIL wr_stall cyc=%0d got=%b/%b/%h/%h/%b exp=1/1/2000/55aa/10", c,
                 o_dport_req_valid, o_dport_write, o_dport_addr, o_dport_wdata, o_dport_size);
      end
      tick();
    end
    i_dport_req_ready  = 1'b1;
    i_dport_resp_valid = 1'b1;
    tick();
    tick();
    checks++;
    if ({o_resp_valid, o_resp_error, o_tmo_cnt} !== {2'b10, 1'b0, 8'd0}) begin
      failures++;
      $display("FAIL wr_resp got=%b/%b/%0d exp=10/0/0", o_resp_valid, o_resp_error, o_tmo_cnt);
    end
    clear_inputs();
    i_resp_ready = 2'b10;
    tick();
    clear_inputs();
  endtask

  task automatic test_timeout_drain();
    int lat = 0;
    reset_dut();
    i_req_valid       = 2'b01;
    i_req_addr        = {64'h0, 64'h3000};
    i_dport_req_ready = 1'b1;
    tick();
    i_req_valid = 2'b00;
    tick();
    while (o_resp_valid == 2'b00 && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != 16) begin
      failures++;
      $display("FAIL tmo_latency got=%0d exp=16", lat);
    end
    checks++;
    if ({o_resp_valid, o_resp_rdata, o_resp_error, o_tmo_cnt} !== {2'b01, 64'h0, 1'b1, 8'd1}) begin
      failures++;
      $display("FAIL tmo_resp got=%b/%h/%b/%0d exp=01/0/1/1", o_resp_valid, o_resp_rdata, o_resp_error, o_tmo_cnt);
    end
    i_resp_ready = 2'b01;
    tick();
    i_resp_ready = 2'b00;
    i_req_valid  = 2'b01;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({o_req_ready, o_dport_resp_ready, o_busy} !== 4'b0011) begin
        failures++;
        $display("FAIL drain_hold cyc=%0d got=%b exp=0011", c, {o_req_ready, o_dport_resp_ready, o_busy});
      end
      tick();
    end
    i_dport_resp_valid = 1'b1;
    i_dport_rdata      = 64'hBAD;
    #1;
    checks++;
    if (o_req_ready !== 2'b00) begin
      failures++;
      $display("FAIL drain_no_grant got=%b exp=00", o_req_ready);
    end
    tick();
    i_dport_resp_valid = 1'b0;
    #1;
    checks++;
    if ({o_req_ready, o_busy, o_resp_valid} !== 5'b01000) begin
      failures++;
      $display("FAIL drain_regrant got=%b exp=01000", {o_req_ready, o_busy, o_resp_valid});
    end
    clear_inputs();
  endtask

  task automatic test_resp_at_max();
    reset_dut();
    i_req_valid       = 2'b10;
    i_dport_req_ready = 1'b1;
    tick();
    i_req_valid = 2'b00;
    tick();
    repeat (15) tick();
    i_dport_resp_valid = 1'b1;
    i_dport_rdata      = 64'h1234;
    tick();
    i_dport_resp_valid = 1'b0;
    checks++;
    if ({o_resp_valid, o_resp_rdata, o_resp_error, o_tmo_cnt} !== {2'b10, 64'h1234, 1'b0, 8'd0}) begin
      failures++;
      $display("FAIL max_resp got=%b/%h/%b/%0d exp=10/1234/0/0", o_resp_valid, o_resp_rdata, o_resp_error, o_tmo_cnt);
    end
    i_resp_ready = 2'b10;
    tick();
    checks++;
    if ({o_busy, o_dport_resp_ready} !== 2'b00) begin
      failures++;
      $display("FAIL max_no_drain got=%b exp=00", {o_busy, o_dport_resp_ready});
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    reset_dut();
    run_txn(0);
    i_req_valid        = 2'b10;
    i_req_addr         = {64'h4000, 64'h0};
    i_dport_req_ready  = 1'b1;
    i_dport_resp_valid = 1'b1;
    i_dport_rdata      = 64'h77;
    tick();
    i_req_valid = 2'b00;
    tick();
    tick();
    checks++;
    if (o_resp_valid !== 2'b10) begin
      failures++;
      $display("FAIL mid_deliver got=%b exp=10", o_resp_valid);
    end
    i_rst = 1'b1;
    #1;
    checks++;
    if ({o_req_ready, o_resp_valid, o_dport_req_valid, o_dport_resp_ready, o_busy, o_resp_error} !== 8'b0 ||
        {o_resp_rdata, o_dport_addr} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs got=%b/%h/%h exp=0", {o_resp_valid, o_busy}, o_resp_rdata, o_dport_addr);
    end
    clear_inputs();
    tick();
    i_rst = 1'b0;
    tick();
    i_req_valid = 2'b11;
    #1;
    checks++;
    if (o_req_ready !== 2'b01) begin
      failures++;
      $display("FAIL mid_next_grant got=%b exp=01", o_req_ready);
    end
    clear_inputs();
  endtask

  initial begin
    i_rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_req_stall();
    test_timeout_drain();
    test_resp_at_max();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
